// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg                                                        |
// | State encoding, time limits and divider helper for stopwatch_counter |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] CENTI_MAX = 8'd99;
  localparam logic [7:0] SEC_MAX   = 8'd59;

  // Number of system clocks per count step.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_counter_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_prescaler                                                       |
// | Divides clk by DIV while enabled; holds its phase while disabled     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic Tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Phase counter: advances only while enabled, so a pause keeps the fraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign Tick = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_counter                                                    |
// | Run/pause/clear/lap stopwatch core with MM:SS.CC binary outputs      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       StartStop,
  input  logic       Clear,
  input  logic       Lap,
  output logic [7:0] Centi,
  output logic [7:0] Seconds,
  output logic [7:0] Minutes,
  output logic       Running,
  output logic       LapHeld,
  output logic       Overflow,
  output logic       Tick
);

  localparam int         DIV      = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [7:0] LAST_MIN = 8'(MAX_MIN);

  state_t     state, state_nxt;
  logic [7:0] live_c, live_s, live_m;
  logic [7:0] live_c_nxt, live_s_nxt, live_m_nxt;
  logic [7:0] snap_c, snap_s, snap_m;
  logic [7:0] snap_c_nxt, snap_s_nxt, snap_m_nxt;
  logic       held_nxt, ovf_nxt;
  logic       at_max, clear_now;

  // Clear is honoured everywhere except RUN; it also resets the sub-tick phase.
  assign clear_now = Clear && (state != RUN);
  assign at_max    = (live_m == LAST_MIN) && (live_s == SEC_MAX) && (live_c == CENTI_MAX);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .clr   (clear_now),
    .Tick  (Tick)
  );

  // Next state, cascaded time counters, lap capture and overflow.
  always_comb begin
    state_nxt  = state;
    live_c_nxt = live_c;
    live_s_nxt = live_s;
    live_m_nxt = live_m;
    snap_c_nxt = snap_c;
    snap_s_nxt = snap_s;
    snap_m_nxt = snap_m;
    held_nxt   = LapHeld;
    ovf_nxt    = Overflow;

    if (Tick) begin
      if (at_max) begin
        ovf_nxt = 1'b1;
      end else if (live_c == CENTI_MAX) begin
        live_c_nxt = 8'd0;
        if (live_s == SEC_MAX) begin
          live_s_nxt = 8'd0;
          live_m_nxt = live_m + 8'd1;
        end else begin
          live_s_nxt = live_s + 8'd1;
        end
      end else begin
        live_c_nxt = live_c + 8'd1;
      end
    end

    unique case (state)
      IDLE: begin
        if (StartStop) state_nxt = RUN;
      end
      RUN: begin
        // Reaching the limit forces a pause even without a button press.
        if (StartStop || (Tick && at_max)) state_nxt = PAUSE;
        if (Lap) begin
          if (LapHeld) begin
            held_nxt = 1'b0;
          end else begin
            held_nxt   = 1'b1;
            snap_c_nxt = live_c;
            snap_s_nxt = live_s;
            snap_m_nxt = live_m;
          end
        end
      end
      PAUSE: begin
        if (StartStop && !Overflow) state_nxt = RUN;
        if (Lap) held_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    // Clear overrides any simultaneous StartStop or Lap.
    if (clear_now) begin
      state_nxt  = IDLE;
      live_c_nxt = 8'd0;
      live_s_nxt = 8'd0;
      live_m_nxt = 8'd0;
      snap_c_nxt = 8'd0;
      snap_s_nxt = 8'd0;
      snap_m_nxt = 8'd0;
      held_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
    end
  end

  // Core state: FSM, live time, snapshot and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      live_c   <= 8'd0;
      live_s   <= 8'd0;
      live_m   <= 8'd0;
      snap_c   <= 8'd0;
      snap_s   <= 8'd0;
      snap_m   <= 8'd0;
      LapHeld  <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      live_c   <= live_c_nxt;
      live_s   <= live_s_nxt;
      live_m   <= live_m_nxt;
      snap_c   <= snap_c_nxt;
      snap_s   <= snap_s_nxt;
      snap_m   <= snap_m_nxt;
      LapHeld  <= held_nxt;
      Overflow <= ovf_nxt;
    end
  end

  // Display registers load the post-edge mux so a tick shows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Centi   <= 8'd0;
      Seconds <= 8'd0;
      Minutes <= 8'd0;
      Running <= 1'b0;
    end else begin
      Centi   <= held_nxt ? snap_c_nxt : live_c_nxt;
      Seconds <= held_nxt ? snap_s_nxt : live_s_nxt;
      Minutes <= held_nxt ? snap_m_nxt : live_m_nxt;
      Running <= (state_nxt == RUN);
    end
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timekeeping core of the stopwatch; sits directly upstream of BCDEncoder.
- Divides the system clock to a 1/100 s tick and keeps minutes, seconds and centiseconds as three independent 8-bit binary values (each 0-99, within BCDEncoder's 0-255 input range).
- Run/pause/clear/lap control: a small FSM driven by single-cycle button pulses from the debounce stage.
- Each value output feeds one BCDEncoder instance; the display driver consumes the BCD result.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. DIV = CLK_HZ/TICK_HZ. CLK_HZ must be an integer multiple of TICK_HZ, with DIV >= 2.
- MAX_MIN, 99, highest minute value, range 1-99. Reduced only in simulation.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- StartStop  in  1  one-cycle pulse: start or pause.
- Clear  in  1  one-cycle pulse: zero the time.
- Lap  in  1  one-cycle pulse: freeze or release the displayed time.
- Centi  out  8  displayed centiseconds, 0-99.
- Seconds  out  8  displayed seconds, 0-59.
- Minutes  out  8  displayed minutes, 0-MAX_MIN.
- Running  out  1  high in the RUN state.
- LapHeld  out  1  high while the displayed time is frozen.
- Overflow  out  1  high after the maximum count is reached; stays high until Clear.
- Tick  out  1  combinational; high in the cycle the time advances.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; prescaler, live time and snapshot all 0.
  - All outputs 0.
  - Reset mid-run aborts immediately; there is no resume.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: StartStop -> RUN. Clear -> stays in IDLE. Lap ignored.
  - RUN: StartStop -> PAUSE. Clear ignored. Lap toggles LapHeld.
  - PAUSE: StartStop -> RUN. Clear -> IDLE. Lap releases the hold if LapHeld=1; otherwise ignored.
  - Simultaneous StartStop and Clear in PAUSE: Clear wins, next state IDLE.
  - Simultaneous StartStop and Lap in RUN: both take effect. The snapshot is taken from the pre-edge live time.
- Prescaler:
  - Counts 0..DIV-1 only in RUN, then wraps to 0.
  - Holds its value in PAUSE, so the sub-tick fraction is retained across a pause.
  - Cleared on entry to IDLE.
  - Tick = (state==RUN) && (prescaler==DIV-1).
- Time update (registered): on the clock edge where Tick=1, live time increments and is visible the next cycle.
  - Centi 99 -> 0, with carry into seconds.
  - Seconds 59 -> 0, with carry into minutes.
  - At MAX_MIN:59.99, a Tick does not increment. Instead: state -> PAUSE, Overflow=1, time holds at MAX_MIN:59.99.
  - StartStop while Overflow=1 is ignored. Only Clear or reset exits this condition.
- Lap:
  - When LapHeld goes 0 -> 1, the snapshot registers capture the live time.
  - While LapHeld=1 the outputs show the snapshot and the live count continues.
  - On release, the outputs show live time from the next cycle.
- Clear:
  - Live time, snapshot, prescaler, LapHeld and Overflow all go to 0 on the same edge.
- Output timing:
  - Centi, Seconds and Minutes are registered muxes: LapHeld ? snapshot : live.
  - Latency from a Tick to a visible output change is 1 cycle.
  - Running is registered from the state.
- Widths: all time registers are 8 bits. The prescaler width is $clog2(DIV). No value ever exceeds 99.

Decomposition:
- Shared package/include stopwatch_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - constants CENTI_MAX=99 and SEC_MAX=59.
  - function computing DIV.
- One sub-module: tick_prescaler.
  - Parameter DIV.
  - Ports: clk, rst_n, en, clr, Tick.
- The FSM, the cascaded counters and the lap mux stay in stopwatch_counter.

Test Plan:
(All cases use CLK_HZ=1000, TICK_HZ=100, so DIV=10.)
1. Basic count: release reset, pulse StartStop, run 1000 cycles -> Minutes=0, Seconds=1, Centi=0, Running=1, exactly 100 Tick pulses.
2. Fraction retention: start, wait 25 cycles, pulse StartStop, idle 500 cycles, pulse StartStop again -> Centi=2 during the pause; the next Tick arrives 5 cycles after resuming; Centi=3 on the following cycle.
3. Carry: run 5999 ticks -> 0:59.99; one more tick -> Minutes=1, Seconds=0, Centi=0.
4. Overflow (MAX_MIN=1): run 11999 ticks -> 1:59.99; next Tick -> Running=0, Overflow=1, time held. StartStop is ignored. Clear -> all outputs 0, Overflow=0.
5. Lap: Lap pulse at 0:03.47 -> outputs frozen at 3, 47 while 200 more ticks elapse. Lap again -> outputs show 0:05.47 the next cycle.
6. Priority and reset: Clear during RUN -> ignored. In PAUSE, StartStop and Clear in the same cycle -> IDLE, all zero. Drop rst_n mid-run between clock edges -> outputs 0 immediately, without waiting for clk.
